// File: rtl/axilite_sram_bridge.sv
// axilite_sram_bridge: AXI-Lite slave mapped onto a 128-bit single-port SRAM.
// One transaction in flight; reads return the 32-bit lane picked by addr[3:2].
module axilite_sram_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   readAddr_addr,
    input  logic          readAddr_valid,
    output logic          readAddr_ready,
    output logic [31:0]   readData_data,
    output logic          readData_valid,
    input  logic          readData_ready,
    input  logic [31:0]   writeAddr_addr,
    input  logic          writeAddr_valid,
    output logic          writeAddr_ready,
    input  logic [127:0]  writeData_data,
    input  logic [15:0]   writeData_strb,
    input  logic          writeData_valid,
    output logic          writeData_ready,
    output logic [31:0]   writeResp_msg,
    output logic          writeResp_valid,
    input  logic          writeResp_ready,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [127:0]  sram_wdata,
    output logic [15:0]   sram_wmask,
    input  logic [127:0]  sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_SEL,
        RD_RESP,
        WR_MEM,
        WR_RESP
    } state_t;

    localparam logic [32:0] SPAN = 33'(DEPTH) << 4;

    state_t      state;
    logic        lastWr;
    logic [1:0]  laneSel;
    logic [31:0] rdOff;
    logic [31:0] wrOff;
    logic        rdIn;
    logic        wrIn;
    logic        wantRd;
    logic        wantWr;
    logic        grantRd;
    logic        grantWr;

    assign rdOff = readAddr_addr - ADDR_BASE;
    assign wrOff = writeAddr_addr - ADDR_BASE;
    assign rdIn  = (readAddr_addr >= ADDR_BASE) && ({1'b0, rdOff} < SPAN);
    assign wrIn  = (writeAddr_addr >= ADDR_BASE) && ({1'b0, wrOff} < SPAN);

    // A write needs both address and data present before it can be granted.
    assign wantRd  = readAddr_valid;
    assign wantWr  = writeAddr_valid && writeData_valid;
    assign grantWr = (state == IDLE) && wantWr && (!wantRd || !lastWr);
    assign grantRd = (state == IDLE) && wantRd && !grantWr;

    assign readAddr_ready  = grantRd;
    assign writeAddr_ready = grantWr;
    assign writeData_ready = grantWr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            lastWr          <= 1'b0;
            laneSel         <= 2'd0;
            sram_cs         <= 1'b0;
            sram_we         <= 1'b0;
            sram_addr       <= '0;
            sram_wdata      <= '0;
            sram_wmask      <= '0;
            readData_data   <= '0;
            readData_valid  <= 1'b0;
            writeResp_msg   <= '0;
            writeResp_valid <= 1'b0;
        end else begin
            sram_cs <= 1'b0;
            sram_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grantWr) begin
                        lastWr <= 1'b1;
                        if (wrIn && |writeData_strb) begin
                            sram_cs    <= 1'b1;
                            sram_we    <= 1'b1;
                            sram_addr  <= wrOff[AW+3:4];
                            sram_wdata <= writeData_data;
                            sram_wmask <= writeData_strb;
                            state      <= WR_MEM;
                        end else begin
                            writeResp_msg   <= wrIn ? 32'd0 : 32'd1;
                            writeResp_valid <= 1'b1;
                            state           <= WR_RESP;
                        end
                    end else if (grantRd) begin
                        lastWr <= 1'b0;
                        if (rdIn) begin
                            sram_cs   <= 1'b1;
                            sram_addr <= rdOff[AW+3:4];
                            laneSel   <= rdOff[3:2];
                            state     <= RD_MEM;
                        end else begin
                            readData_data  <= ERR_DATA;
                            readData_valid <= 1'b1;
                            state          <= RD_RESP;
                        end
                    end
                end
                RD_MEM: begin
                    state <= RD_SEL;
                end
                RD_SEL: begin
                    readData_data  <= sram_rdata[{laneSel, 5'd0} +: 32];
                    readData_valid <= 1'b1;
                    state          <= RD_RESP;
                end
                RD_RESP: begin
                    if (readData_ready) begin
                        readData_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                WR_MEM: begin
                    writeResp_msg   <= 32'd0;
                    writeResp_valid <= 1'b1;
                    state           <= WR_RESP;
                end
                WR_RESP: begin
                    if (writeResp_ready) begin
                        writeResp_valid <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_sram_bridge.sv
// tb_axilite_sram_bridge: scoreboard bench for the AXI-Lite to SRAM bridge.
// Expected responses are queued at stimulus time and popped as the DUT answers.
module tb_axilite_sram_bridge;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   readAddr_addr;
    logic          readAddr_valid;
    logic          readAddr_ready;
    logic [31:0]   readData_data;
    logic          readData_valid;
    logic          readData_ready;
    logic [31:0]   writeAddr_addr;
    logic          writeAddr_valid;
    logic          writeAddr_ready;
    logic [127:0]  writeData_data;
    logic [15:0]   writeData_strb;
    logic          writeData_valid;
    logic          writeData_ready;
    logic [31:0]   writeResp_msg;
    logic          writeResp_valid;
    logic          writeResp_ready;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [127:0]  sram_wdata;
    logic [15:0]   sram_wmask;
    logic [127:0]  sram_rdata;

    axilite_sram_bridge dut (
        .clk(clk),
        .rst_n(rst_n),
        .readAddr_addr(readAddr_addr),
        .readAddr_valid(readAddr_valid),
        .readAddr_ready(readAddr_ready),
        .readData_data(readData_data),
        .readData_valid(readData_valid),
        .readData_ready(readData_ready),
        .writeAddr_addr(writeAddr_addr),
        .writeAddr_valid(writeAddr_valid),
        .writeAddr_ready(writeAddr_ready),
        .writeData_data(writeData_data),
        .writeData_strb(writeData_strb),
        .writeData_valid(writeData_valid),
        .writeData_ready(writeData_ready),
        .writeResp_msg(writeResp_msg),
        .writeResp_valid(writeResp_valid),
        .writeResp_ready(writeResp_ready),
        .sram_cs(sram_cs),
        .sram_we(sram_we),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_wmask(sram_wmask),
        .sram_rdata(sram_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [127:0] mergeLine(input logic [127:0] old,
                                               input logic [127:0] d,
                                               input logic [15:0] s);
        logic [127:0] r;
        r = old;
        for (int i = 0; i < 16; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    logic [127:0] sramArr [DEPTH];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we)
                sramArr[sram_addr] <= mergeLine(sramArr[sram_addr], sram_wdata, sram_wmask);
            else
                sram_rdata <= sramArr[sram_addr];
        end
    end

    logic [127:0]  model [DEPTH];
    logic [31:0]   rdQ[$];
    logic [31:0]   wrQ[$];
    logic [AW-1:0] expRdLine;
    logic [AW-1:0] expWrLine;
    logic [15:0]   expStrb;
    logic [127:0]  expWdata;
    int            nCompared = 0;
    int            nMismatch = 0;

    task automatic checkVal(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit inRange(input logic [31:0] a);
        return a < 32'(DEPTH * 16);
    endfunction

    task automatic startRd(input logic [31:0] a);
        logic [127:0] line;
        readAddr_addr  = a;
        readAddr_valid = 1'b1;
        if (inRange(a)) begin
            expRdLine = a[AW+3:4];
            line      = model[a[AW+3:4]];
            rdQ.push_back(line[{a[3:2], 5'd0} +: 32]);
        end else begin
            rdQ.push_back(32'hDEAD_BEEF);
        end
    endtask

    task automatic startWr(input logic [31:0] a, input logic [127:0] d,
                           input logic [15:0] s);
        writeAddr_addr  = a;
        writeData_data  = d;
        writeData_strb  = s;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        expStrb         = s;
        expWdata        = d;
        if (inRange(a)) begin
            expWrLine = a[AW+3:4];
            if (s != 16'd0)
                model[a[AW+3:4]] = mergeLine(model[a[AW+3:4]], d, s);
            wrQ.push_back(32'd0);
        end else begin
            wrQ.push_back(32'd1);
        end
    endtask

    task automatic finishRd(input int expLat, input int hold,
                            input bit queueNext, input logic [31:0] nextA);
        int n;
        bit ok;
        logic [31:0] exp;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (readAddr_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checkVal("rd_accept_timeout", 128'(0), 128'(1));
            readAddr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n  = 0;
        ok = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                readAddr_valid = 1'b0;
                if (expLat == 3) begin
                    checkVal("rd_sram_cs", 128'(sram_cs), 128'(1));
                    checkVal("rd_sram_we", 128'(sram_we), 128'(0));
                    checkVal("rd_sram_addr", 128'(sram_addr), 128'(expRdLine));
                end else begin
                    checkVal("rd_oor_no_cs", 128'(sram_cs), 128'(0));
                end
            end
            if (readData_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checkVal("rd_resp_timeout", 128'(0), 128'(1));
            return;
        end
        checkVal("rd_latency", 128'(n), 128'(expLat));
        if (rdQ.size() == 0) begin
            checkVal("rd_queue_underflow", 128'(0), 128'(1));
            return;
        end
        exp = rdQ.pop_front();
        checkVal("rd_data", 128'(readData_data), 128'(exp));
        if (queueNext) startRd(nextA);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checkVal("bp_valid", 128'(readData_valid), 128'(1));
            checkVal("bp_data", 128'(readData_data), 128'(exp));
            checkVal("bp_no_arready", 128'(readAddr_ready), 128'(0));
        end
        readData_ready = 1'b1;
        @(negedge clk);
        checkVal("rd_valid_drop", 128'(readData_valid), 128'(0));
    endtask

    task automatic finishWr(input int expLat);
        int n;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (writeAddr_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checkVal("wr_accept_timeout", 128'(0), 128'(1));
            writeAddr_valid = 1'b0;
            writeData_valid = 1'b0;
            return;
        end
        checkVal("wr_ready_pair", 128'(writeData_ready), 128'(1));
        @(posedge clk);
        n  = 0;
        ok = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                writeAddr_valid = 1'b0;
                writeData_valid = 1'b0;
                if (expLat == 2) begin
                    checkVal("wr_sram_cs", 128'(sram_cs), 128'(1));
                    checkVal("wr_sram_we", 128'(sram_we), 128'(1));
                    checkVal("wr_sram_addr", 128'(sram_addr), 128'(expWrLine));
                    checkVal("wr_sram_wmask", 128'(sram_wmask), 128'(expStrb));
                    checkVal("wr_sram_wdata", sram_wdata, expWdata);
                end else begin
                    checkVal("wr_no_cs", 128'(sram_cs), 128'(0));
                end
            end
            if (writeResp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checkVal("wr_resp_timeout", 128'(0), 128'(1));
            return;
        end
        checkVal("wr_latency", 128'(n), 128'(expLat));
        if (wrQ.size() == 0) begin
            checkVal("wr_queue_underflow", 128'(0), 128'(1));
            return;
        end
        checkVal("wr_msg", 128'(writeResp_msg), 128'(wrQ.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst_n           = 1'b0;
        readAddr_addr   = '0;
        readAddr_valid  = 1'b0;
        readData_ready  = 1'b1;
        writeAddr_addr  = '0;
        writeAddr_valid = 1'b0;
        writeData_data  = '0;
        writeData_strb  = '0;
        writeData_valid = 1'b0;
        writeResp_ready = 1'b1;

        @(negedge clk);
        checkVal("rst_rvalid", 128'(readData_valid), 128'(0));
        checkVal("rst_bvalid", 128'(writeResp_valid), 128'(0));
        checkVal("rst_cs", 128'(sram_cs), 128'(0));
        checkVal("rst_we", 128'(sram_we), 128'(0));
        checkVal("rst_addr", 128'(sram_addr), 128'(0));
        checkVal("rst_wmask", 128'(sram_wmask), 128'(0));
        checkVal("rst_wdata", sram_wdata, 128'(0));
        checkVal("rst_rdata", 128'(readData_data), 128'(0));
        checkVal("rst_msg", 128'(writeResp_msg), 128'(0));
        checkVal("rst_arready", 128'(readAddr_ready), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // full-line write, then every lane of it
        startWr(32'h10, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF);
        finishWr(2);
        for (int i = 0; i < 4; i++) begin
            startRd(32'h10 + 32'(4 * i));
            finishRd(3, 0, 1'b0, 32'h0);
        end

        // partial strobes, zero strobe, last line
        startWr(32'h20, {16{8'hAA}}, 16'hFFFF);
        finishWr(2);
        startWr(32'h20, {16{8'h55}}, 16'h000F);
        finishWr(2);
        startRd(32'h20);
        finishRd(3, 0, 1'b0, 32'h0);
        startRd(32'h24);
        finishRd(3, 0, 1'b0, 32'h0);
        startWr(32'h30, {16{8'h77}}, 16'h0000);
        finishWr(1);
        startWr(32'h3FF0, 128'h1234_5678_9ABC_DEF0_0BAD_F00D_CAFE_BABE, 16'hF0F0);
        finishWr(2);
        startRd(32'h3FFC);
        finishRd(3, 0, 1'b0, 32'h0);

        // out of range
        startWr(32'h4000, {16{8'h11}}, 16'hFFFF);
        finishWr(1);
        startRd(32'h4000);
        finishRd(1, 0, 1'b0, 32'h0);

        // reset while a read sits in RD_SEL
        readAddr_addr  = 32'h10;
        readAddr_valid = 1'b1;
        #1;
        checkVal("rst_mid_accept", 128'(readAddr_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        readAddr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("rst_mid_rvalid", 128'(readData_valid), 128'(0));
        checkVal("rst_mid_cs", 128'(sram_cs), 128'(0));
        checkVal("rst_mid_arready", 128'(readAddr_ready), 128'(0));
        checkVal("rst_mid_awready", 128'(writeAddr_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("rst_mid_no_resp", 128'(readData_valid), 128'(0));
        end

        // simultaneous requests alternate, write first after reset
        startRd(32'h14);
        startWr(32'h40, {16{8'h3C}}, 16'hFFFF);
        #1;
        checkVal("arb1_awready", 128'(writeAddr_ready), 128'(1));
        checkVal("arb1_arready", 128'(readAddr_ready), 128'(0));
        finishWr(2);
        startWr(32'h50, {16{8'hC3}}, 16'h00FF);
        @(negedge clk);
        #1;
        checkVal("arb2_arready", 128'(readAddr_ready), 128'(1));
        checkVal("arb2_awready", 128'(writeAddr_ready), 128'(0));
        finishRd(3, 0, 1'b0, 32'h0);
        finishWr(2);

        // backpressure on read data
        readData_ready = 1'b0;
        startRd(32'h18);
        finishRd(3, 5, 1'b1, 32'h1C);
        finishRd(3, 0, 1'b0, 32'h0);

        checkVal("rdq_empty", 128'(rdQ.size()), 128'(0));
        checkVal("wrq_empty", 128'(wrQ.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
